// File: rtl/wide_add_pkg.sv
// Shared types and defaults for the sliced wide-add sequencer.
// The optional subtract mode is controlled by the WIDE_ADD_SEQ_SUB_EN macro in wide_add_seq.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WORD_W    = 16;
  localparam int DEF_NUM_WORDS = 4;

  // Slice index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational WORD_W-bit slice adder with carry-in and carry-out.
module add_slice #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cin_i};

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle NUM_WORDS x WORD_W adder built on one shared slice adder, LSB slice first.
// Define WIDE_ADD_SEQ_SUB_EN to add the sub_i port (A - B via inverted B and forced carry-in).
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter  int WORD_W    = DEF_WORD_W,
  parameter  int NUM_WORDS = DEF_NUM_WORDS,
  localparam int N         = WORD_W * NUM_WORDS,
  localparam int IW        = idx_w(NUM_WORDS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic         sub_i,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         busy_o
);

  state_e                            state_q;
  logic [IW-1:0]                     idx_q;
  logic                              carry_q;
  logic                              cout_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0]  a_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0]  b_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0]  sum_q;

  logic [N-1:0]      b_d;
  logic              carry_d;
  logic [WORD_W-1:0] slice_sum;
  logic              slice_cout;

  // Operand conditioning happens once at acceptance so the slice path stays a plain adder.
  always_comb begin
    b_d     = b_i;
    carry_d = cin_i;
`ifdef WIDE_ADD_SEQ_SUB_EN
    if (sub_i) begin
      b_d     = ~b_i;
      carry_d = 1'b1;
    end
`endif
  end

  add_slice #(.WORD_W(WORD_W)) u_slice (
    .a_i   (a_q[idx_q]),
    .b_i   (b_q[idx_q]),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a_i;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q] <= slice_sum;
          carry_q      <= slice_cout;
          if (idx_q == IW'(NUM_WORDS - 1)) begin
            cout_q  <= slice_cout;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy_o    = (state_q != IDLE);
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: cycle-level reference model plus directed and random operations.
module tb_wide_add_seq;

  localparam int NW = 4;
  localparam int N  = 64;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin_i, out_valid, out_ready, cout_o, busy_o;
  logic         sub;
  logic [N-1:0] a_i, b_i, sum_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wide_add_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_i      (a_i),
    .b_i      (b_i),
    .cin_i    (cin_i),
`ifdef WIDE_ADD_SEQ_SUB_EN
    .sub_i    (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum_o    (sum_o),
    .cout_o   (cout_o),
    .busy_o   (busy_o)
  );

  task automatic chk(input string name, input logic [N:0] got, input logic [N:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Full-width arithmetic: the carry out is bit N of the 65-bit sum.
  function automatic logic [N:0] model_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic c, input logic s);
    if (s) return {1'b0, a} - {1'b0, b} + {1'b1, {N{1'b0}}};
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
  endfunction

  // Reference model: result appears NW edges after acceptance, held until handshake.
  int          edge_cnt = 0;
  int          m_done   = 0;
  bit          m_busy   = 0;
  bit          m_valid  = 0;
  bit          m_known  = 0;
  logic [N:0]  m_exp    = '0;
  logic [N:0]  m_res    = '0;

  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      m_busy  = 0;
      m_valid = 0;
      m_known = 1;
      m_res   = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy  = 1;
        m_done  = edge_cnt + NW;
        m_exp   = model_add(a_i, b_i, cin_i, sub);
        m_known = 0;
      end
    end else if (m_valid && out_ready) begin
      m_busy  = 0;
      m_valid = 0;
    end
    if (m_busy && !m_valid && edge_cnt >= m_done) begin
      m_valid = 1;
      m_res   = m_exp;
      m_known = 1;
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {{N{1'b0}}, in_ready}, {{N{1'b0}}, !m_busy});
      chk("busy", {{N{1'b0}}, busy_o}, {{N{1'b0}}, m_busy});
      chk("out_valid", {{N{1'b0}}, out_valid}, {{N{1'b0}}, m_valid});
      if (m_known) chk("result", {cout_o, sum_o}, m_res);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                      input logic s, output int acc_edge);
    a_i = a; b_i = b; cin_i = c; sub = s; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_busy) break;
    end
    checks++;
    if (!m_busy) begin
      errors++;
      $display("FAIL accept_timeout: request not taken");
    end
    acc_edge = edge_cnt;
    in_valid = 1'b0;
    a_i   = {$urandom, $urandom};
    b_i   = {$urandom, $urandom};
    cin_i = 1'($urandom);
`ifdef WIDE_ADD_SEQ_SUB_EN
    sub   = 1'($urandom);
`endif
  endtask

  task automatic wait_res(input int acc_edge, output logic [N:0] res);
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      step();
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL result_timeout: out_valid never rose");
    end
    chk("latency", N'(edge_cnt - acc_edge), N'(NW));
    res = {cout_o, sum_o};
  endtask

  task automatic release_res(input int hold);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      a_i = {$urandom, $urandom};
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("in_ready_after_hs", {{N{1'b0}}, in_ready}, 65'd1);
  endtask

  task automatic op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic c, input logic s, input int hold, input logic [N:0] exp);
    int         acc;
    logic [N:0] res;
    send(a, b, c, s, acc);
    wait_res(acc, res);
    chk(name, res, exp);
    release_res(hold);
  endtask

  initial begin
    int         acc;
    logic [N:0] res;
    logic [N-1:0] ra, rb;
    logic rc, rs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_i = '0; b_i = '0; cin_i = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1;
    chk("rst_in_ready", {{N{1'b0}}, in_ready}, 65'd1);
    chk("rst_out_valid", {{N{1'b0}}, out_valid}, 65'd0);
    chk("rst_sum", {cout_o, sum_o}, 65'd0);

    op("zero",        64'h0, 64'h0, 1'b0, 1'b0, 0, 65'h0);
    op("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, 65'h0_0000_0000_0001_0000);
    op("full_wrap",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 65'h1_0000_0000_0000_0000);
    op("cin_only",    64'h0, 64'h0, 1'b1, 1'b0, 0, 65'h0_0000_0000_0000_0001);
    op("hold5",       64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, 1'b0, 5,
       65'h0_0011_0022_0033_0044);

    // Abort during the second RUN cycle.
    send(64'h1111, 64'h2222, 1'b0, 1'b0, acc);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", {{N{1'b0}}, in_ready}, 65'd1);
    chk("abort_out_valid", {{N{1'b0}}, out_valid}, 65'd0);
    chk("abort_sum", {{1'b0}, sum_o}, 65'd0);
    op("after_abort", 64'd3, 64'd4, 1'b0, 1'b0, 0, 65'd7);

`ifdef WIDE_ADD_SEQ_SUB_EN
    op("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1, 0, 65'h0_FFFF_FFFF_FFFF_FFFE);
    op("sub_7_5", 64'd7, 64'd5, 1'b0, 1'b1, 0, 65'h1_0000_0000_0000_0002);
`endif

    for (int t = 0; t < 40; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (t % 7 == 0) ra = '1;
      if (t % 11 == 3) rb = '1;
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef WIDE_ADD_SEQ_SUB_EN
      rs = 1'($urandom);
`endif
      send(ra, rb, rc, rs, acc);
      wait_res(acc, res);
      chk("random", res, model_add(ra, rb, rc, rs));
      release_res($urandom_range(0, 3));
    end

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
